// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use bubbles, redirect flushes, memory back-pressure.
// Optional HAZ_PERF_CNT_EN adds wrapping perf counters for lu stalls, redirect flushes and mem stalls.
module ex_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_stall,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [FWD_W-1:0]      forward_op1,
    output logic [FWD_W-1:0]      forward_op2,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]           perf_lu_cnt,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_memstall_cnt,
`endif
    output logic                  ex_busy_valid
);

    localparam logic [FWD_W-1:0] FORWARD_NONE = '0;
    localparam logic [FWD_W-1:0] FORWARD_MEM  = FWD_W'(1);
    localparam logic [FWD_W-1:0] FORWARD_WB   = FWD_W'(2);

    logic                  ex_valid, ex_we, ex_load;
    logic                  mem_valid, mem_we;
    logic                  wb_valid, wb_we;
    logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
    logic                  lu, bubble;
    logic [FWD_W-1:0]      fwd1_next, fwd2_next;

    // WB shadow is kept for debug visibility only; the register file is write-through.
    logic wb_unused;
    assign wb_unused = ^{wb_valid, wb_we, wb_rd};

    always_comb begin
        lu = ex_valid && ex_load && ex_we && (ex_rd != '0) && id_valid &&
             ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;
        ex_busy_valid = !rst && ex_valid;
        if (rst) begin
            stall_if = 1'b0;
        end else if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (lu) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
        bubble = flush_ex || !id_valid;
    end

    // Selects are resolved one cycle early: what sits in EX now will be in MEM when ID reaches EX.
    always_comb begin
        fwd1_next = FORWARD_NONE;
        fwd2_next = FORWARD_NONE;
        if (id_rs1_used && ex_valid && ex_we && (ex_rd == id_rs1))
            fwd1_next = FORWARD_MEM;
        else if (id_rs1_used && mem_valid && mem_we && (mem_rd == id_rs1))
            fwd1_next = FORWARD_WB;
        if (id_rs2_used && ex_valid && ex_we && (ex_rd == id_rs2))
            fwd2_next = FORWARD_MEM;
        else if (id_rs2_used && mem_valid && mem_we && (mem_rd == id_rs2))
            fwd2_next = FORWARD_WB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_we       <= 1'b0;
            ex_load     <= 1'b0;
            ex_rd       <= '0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_rd      <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            forward_op1 <= FORWARD_NONE;
            forward_op2 <= FORWARD_NONE;
        end else if (!mem_stall) begin
            wb_valid  <= mem_valid;
            wb_we     <= mem_we;
            wb_rd     <= mem_rd;
            mem_valid <= ex_valid;
            mem_we    <= ex_we;
            mem_rd    <= ex_rd;
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_we       <= 1'b0;
                ex_load     <= 1'b0;
                ex_rd       <= '0;
                forward_op1 <= FORWARD_NONE;
                forward_op2 <= FORWARD_NONE;
            end else begin
                ex_valid    <= 1'b1;
                ex_we       <= id_reg_write && (id_rd != '0);
                ex_load     <= id_mem_read;
                ex_rd       <= id_rd;
                forward_op1 <= fwd1_next;
                forward_op2 <= fwd2_next;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_cnt       <= '0;
            perf_flush_cnt    <= '0;
            perf_memstall_cnt <= '0;
        end else if (mem_stall) begin
            perf_memstall_cnt <= perf_memstall_cnt + 32'd1;
        end else if (ex_redirect) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end else if (lu) begin
            perf_lu_cnt <= perf_lu_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios then random traffic against an instruction-level pipeline model.
module tb_ex_hazard_ctrl;
    localparam int AW = 5;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_redirect, mem_stall;
    logic          stall_if, stall_id, flush_id, flush_ex, ex_busy_valid;
    logic [FW-1:0] forward_op1, forward_op2;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   perf_lu_cnt, perf_flush_cnt, perf_memstall_cnt;
`endif

    ex_hazard_ctrl #(.REG_ADDR_W(AW), .FWD_W(FW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
        .mem_stall(mem_stall), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .flush_ex(flush_ex), .forward_op1(forward_op1), .forward_op2(forward_op2),
`ifdef HAZ_PERF_CNT_EN
        .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_memstall_cnt(perf_memstall_cnt),
`endif
        .ex_busy_valid(ex_busy_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Instruction-level model: slot 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {bit v; int rd; bit we; bit ld;} ins_t;
    ins_t pipe[3];
    int f1_m, f2_m;
    int unsigned lu_c, fl_c, ms_c;

    function automatic int fwd_of(int rs, bit used);
        for (int k = 0; k < 2; k++)
            if (used && pipe[k].v && pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == rs)
                return k + 1;
        return 0;
    endfunction

    function automatic bit lu_m();
        int r = pipe[0].rd;
        return id_valid && pipe[0].v && pipe[0].ld && pipe[0].we && r != 0 &&
               ((id_rs1_used && int'(id_rs1) == r) || (id_rs2_used && int'(id_rs2) == r));
    endfunction

    // Inputs are driven at the negedge; check #1 later, then advance the model across the posedge.
    task automatic tick();
        bit s, fid, fex, bub;
        int n1, n2;
        #1;
        s = 0; fid = 0; fex = 0;
        if (!rst) begin
            if (mem_stall) s = 1;
            else if (ex_redirect) begin fid = 1; fex = 1; end
            else if (lu_m()) begin s = 1; fex = 1; end
        end
        chk("stall_if", 32'(stall_if), 32'(s));
        chk("stall_id", 32'(stall_id), 32'(s));
        chk("flush_id", 32'(flush_id), 32'(fid));
        chk("flush_ex", 32'(flush_ex), 32'(fex));
        chk("ex_busy_valid", 32'(ex_busy_valid), 32'(!rst && pipe[0].v));
        chk("forward_op1", 32'(forward_op1), 32'(f1_m));
        chk("forward_op2", 32'(forward_op2), 32'(f2_m));
`ifdef HAZ_PERF_CNT_EN
        chk("perf_lu", perf_lu_cnt, lu_c);
        chk("perf_flush", perf_flush_cnt, fl_c);
        chk("perf_memstall", perf_memstall_cnt, ms_c);
`endif
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
            f1_m = 0; f2_m = 0; lu_c = 0; fl_c = 0; ms_c = 0;
        end else if (mem_stall) begin
            ms_c++;
        end else begin
            if (ex_redirect) fl_c++;
            else if (lu_m()) lu_c++;
            bub = fex || !id_valid;
            n1 = fwd_of(int'(id_rs1), id_rs1_used);
            n2 = fwd_of(int'(id_rs2), id_rs2_used);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (bub) begin
                pipe[0] = '{0, 0, 0, 0};
                f1_m = 0; f2_m = 0;
            end else begin
                pipe[0] = '{1, int'(id_rd), id_reg_write, id_mem_read};
                f1_m = n1; f2_m = n2;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                          input int rd, input bit we, input bit ld);
        id_valid = v; id_rs1 = AW'(r1); id_rs2 = AW'(r2); id_rs1_used = u1; id_rs2_used = u2;
        id_rd = AW'(rd); id_reg_write = we; id_mem_read = ld;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_id();
        set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
               $urandom_range(0, 3) == 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        f1_m = 0; f2_m = 0; lu_c = 0; fl_c = 0; ms_c = 0;
        @(negedge clk);

        // Reset with random inputs.
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            ex_redirect = 1'($urandom); mem_stall = 1'($urandom);
            tick();
        end
        rst = 0; ex_redirect = 0; mem_stall = 0; nop();
        #1;
        chk("rst_fwd1", 32'(forward_op1), 0);
        chk("rst_busy", 32'(ex_busy_valid), 0);
        chk("rst_stall", 32'(stall_if), 0);
        tick(); tick(); tick();

        // Back-to-back RAW: add x5 ; add x6,x5,x1.
        set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0); tick();
        nop(); #1;
        chk("b2b_fwd1", 32'(forward_op1), 1);
        chk("b2b_fwd2", 32'(forward_op2), 0);
        chk("b2b_stall", 32'(stall_if), 0);
        tick(); tick(); tick();

        // Double writer: MEM wins; single writer two back: WB.
        set_id(1, 1, 1, 1, 0, 5, 1, 0); tick();
        set_id(1, 2, 2, 1, 0, 5, 1, 0); tick();
        set_id(1, 5, 0, 1, 0, 9, 1, 0); tick();
        nop(); #1;
        chk("dbl_fwd1", 32'(forward_op1), 1);
        tick(); tick();
        set_id(1, 1, 1, 1, 0, 5, 1, 0); tick();
        set_id(1, 2, 2, 1, 0, 3, 1, 0); tick();
        set_id(1, 5, 0, 1, 0, 9, 1, 0); tick();
        nop(); #1;
        chk("wb_fwd1", 32'(forward_op1), 2);
        tick(); tick(); tick();

        // Load-use: lw x7 ; add x8,x7,x7.
        set_id(1, 0, 0, 0, 0, 7, 1, 1); tick();
        set_id(1, 7, 7, 1, 1, 8, 1, 0); #1;
        chk("lu_stall", 32'(stall_if), 1);
        chk("lu_flush_ex", 32'(flush_ex), 1);
        chk("lu_flush_id", 32'(flush_id), 0);
        tick(); #1;
        chk("lu_once", 32'(stall_if), 0);
        tick();
        nop(); #1;
        chk("lu_fwd1", 32'(forward_op1), 2);
        chk("lu_fwd2", 32'(forward_op2), 2);
        tick(); tick(); tick();

        // lw x0 never stalls.
        set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 0, 0, 1, 1, 8, 1, 0); #1;
        chk("x0_nostall", 32'(stall_if), 0);
        tick(); nop(); tick(); tick();

        // Redirect coinciding with lu.
        set_id(1, 0, 0, 0, 0, 7, 1, 1); tick();
        set_id(1, 7, 7, 1, 1, 8, 1, 0); ex_redirect = 1; #1;
        chk("redir_flush_id", 32'(flush_id), 1);
        chk("redir_stall", 32'(stall_if), 0);
        tick();
        ex_redirect = 0; nop(); #1;
        chk("redir_busy", 32'(ex_busy_valid), 0);
        tick(); tick(); tick();

        // mem_stall for 4 cycles in a RAW sequence.
        rst = 1; tick(); rst = 0;
        set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0); mem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1; chk("ms_stall", 32'(stall_if), 1);
            tick();
        end
        mem_stall = 0; tick();
        nop(); #1;
        chk("ms_fwd1", 32'(forward_op1), 1);
`ifdef HAZ_PERF_CNT_EN
        chk("ms_perf", perf_memstall_cnt, 4);
`endif
        tick(); tick(); tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_id();
            ex_redirect = $urandom_range(0, 9) == 0;
            mem_stall   = $urandom_range(0, 6) == 0;
            rst         = $urandom_range(0, 49) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
